// File: rtl/mc_sequencer.sv
// Multi-cycle instruction sequencer: walks each instruction through IF/ID/EXE/MEM/WB,
// waits on memory handshakes with an optional timeout, and keeps retire/stall counters.
`timescale 1ns/1ps
module mc_sequencer #(
   parameter int TIMEOUT    = 15,
   parameter int CNT_W      = 4,
   parameter int EN_TIMEOUT = 1,
   parameter int PERF_W     = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [2:0]        cls_i,
   input  logic              imem_ack_i,
   input  logic              dmem_ack_i,
   input  logic              go_i,
   output logic [2:0]        state_o,
   output logic              imem_req_o,
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   output logic              ir_wre_o,
   output logic              reg_wre_o,
   output logic              pc_wre_o,
   output logic              retire_o,
   output logic              halted_o,
   output logic              err_o,
   output logic [PERF_W-1:0] instret_o,
   output logic [PERF_W-1:0] stall_cnt_o
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EXE  = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5,
      S_ERR  = 3'd6
   } state_t;

   localparam logic [2:0] CLS_ALU    = 3'd0;
   localparam logic [2:0] CLS_LOAD   = 3'd1;
   localparam logic [2:0] CLS_STORE  = 3'd2;
   localparam logic [2:0] CLS_BRANCH = 3'd3;
   localparam logic [2:0] CLS_JUMP   = 3'd4;
   localparam logic [2:0] CLS_HALT   = 3'd5;

   state_t             state_q;
   logic [2:0]         cls_q;
   logic [CNT_W-1:0]   wait_q;
   logic [PERF_W-1:0]  instret_q, instret_d;
   logic [PERF_W-1:0]  stall_q, stall_d;

   logic wait_state, cur_ack, stall_cyc, timeout_hit, retire_int;

   assign wait_state  = (state_q == S_IF) || (state_q == S_MEM);
   assign cur_ack     = ((state_q == S_IF) && imem_ack_i) || ((state_q == S_MEM) && dmem_ack_i);
   assign stall_cyc   = wait_state && !cur_ack;
   assign timeout_hit = (EN_TIMEOUT != 0) && (wait_q == CNT_W'(TIMEOUT));

   assign retire_int = ((state_q == S_ID)  && (cls_i == CLS_JUMP))
                    || ((state_q == S_EXE) && (cls_q == CLS_BRANCH))
                    || ((state_q == S_MEM) && dmem_ack_i && (cls_q == CLS_STORE))
                    ||  (state_q == S_WB);

   // Saturating performance counters
   assign instret_d = (retire_int && (instret_q != '1)) ? instret_q + 1'b1 : instret_q;
   assign stall_d   = (stall_cyc && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;

   // The reset state is IF, so requests and strobes must be masked while reset is held
   assign imem_req_o  = rst_ni && (state_q == S_IF);
   assign dmem_req_o  = rst_ni && (state_q == S_MEM);
   assign dmem_we_o   = dmem_req_o && (cls_q == CLS_STORE);
   assign ir_wre_o    = rst_ni && (state_q == S_IF) && imem_ack_i;
   assign reg_wre_o   = rst_ni && (state_q == S_WB);
   assign pc_wre_o    = rst_ni && retire_int;
   assign retire_o    = rst_ni && retire_int;
   assign halted_o    = (state_q == S_HALT);
   assign err_o       = (state_q == S_ERR);
   assign state_o     = state_q;
   assign instret_o   = instret_q;
   assign stall_cnt_o = stall_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IF;
         cls_q     <= CLS_ALU;
         wait_q    <= '0;
         instret_q <= '0;
         stall_q   <= '0;
      end else begin
         instret_q <= instret_d;
         stall_q   <= stall_d;

         if (!wait_state || cur_ack)
            wait_q <= '0;
         else if (!timeout_hit)
            wait_q <= wait_q + 1'b1;

         case (state_q)
            S_IF: begin
               if (imem_ack_i)       state_q <= S_ID;
               else if (timeout_hit) state_q <= S_ERR;
            end
            S_ID: begin
               cls_q <= cls_i;
               case (cls_i)
                  CLS_JUMP:               state_q <= S_IF;
                  CLS_HALT:               state_q <= S_HALT;
                  3'd6, 3'd7:             state_q <= S_ERR;
                  default:                state_q <= S_EXE;
               endcase
            end
            S_EXE: begin
               case (cls_q)
                  CLS_BRANCH:             state_q <= S_IF;
                  CLS_LOAD, CLS_STORE:    state_q <= S_MEM;
                  default:                state_q <= S_WB;
               endcase
            end
            S_MEM: begin
               if (dmem_ack_i)       state_q <= (cls_q == CLS_STORE) ? S_IF : S_WB;
               else if (timeout_hit) state_q <= S_ERR;
            end
            S_WB:    state_q <= S_IF;
            S_HALT:  if (go_i) state_q <= S_IF;
            S_ERR:   state_q <= S_ERR;
            default: state_q <= S_ERR;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: walks every instruction class, memory waits,
// timeout boundary, HALT/go, illegal class and asynchronous reset mid-instruction.
`timescale 1ns/1ps
module tb_mc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  cls;
   logic        imem_ack, dmem_ack, go;
   logic [2:0]  state;
   logic        imem_req, dmem_req, dmem_we, ir_wre, reg_wre, pc_wre, retire, halted, err;
   logic [31:0] instret, stall_cnt;

   int checks = 0;
   int errors = 0;

   mc_sequencer #(.TIMEOUT(15), .CNT_W(4), .EN_TIMEOUT(1), .PERF_W(32)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .cls_i       (cls),
      .imem_ack_i  (imem_ack),
      .dmem_ack_i  (dmem_ack),
      .go_i        (go),
      .state_o     (state),
      .imem_req_o  (imem_req),
      .dmem_req_o  (dmem_req),
      .dmem_we_o   (dmem_we),
      .ir_wre_o    (ir_wre),
      .reg_wre_o   (reg_wre),
      .pc_wre_o    (pc_wre),
      .retire_o    (retire),
      .halted_o    (halted),
      .err_o       (err),
      .instret_o   (instret),
      .stall_cnt_o (stall_cnt)
   );

   always #5 clk = ~clk;

   // {IRWre, RegWre, PCWre, retire, imem_req, dmem_req, dmem_we}
   function automatic logic [6:0] outs();
      return {ir_wre, reg_wre, pc_wre, retire, imem_req, dmem_req, dmem_we};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst_n = 1'b0; cls = 3'd0; imem_ack = 1'b0; dmem_ack = 1'b0; go = 1'b0;

      // Reset state; IRWre must stay low even with imem_ack high
      #2;
      imem_ack = 1'b1;
      settle();
      chk("rst state", state, 0);
      chk("rst outs", outs(), 7'b0000000);
      chk("rst instret", instret, 0);
      chk("rst stall", stall_cnt, 0);
      chk("rst err", err, 0);
      chk("rst halted", halted, 0);
      imem_ack = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      settle();

      // ALU with immediate ack: 0,1,2,4,0
      imem_ack = 1'b1; settle();
      chk("alu c0 state", state, 0);
      chk("alu c0 outs", outs(), 7'b1000100);
      tick();
      imem_ack = 1'b0; cls = 3'd0; settle();
      chk("alu c1 state", state, 1);
      chk("alu c1 outs", outs(), 7'b0000000);
      tick();
      cls = 3'd3; settle();
      chk("alu c2 state", state, 2);
      chk("alu c2 outs", outs(), 7'b0000000);
      tick();
      settle();
      chk("alu c3 state", state, 4);
      chk("alu c3 outs", outs(), 7'b0111000);
      tick();
      settle();
      chk("alu end state", state, 0);
      chk("alu instret", instret, 1);
      chk("alu stall", stall_cnt, 0);
      $display("instr ALU instret=%0d stall=%0d", instret, stall_cnt);

      // LOAD with dmem_ack delayed 3 cycles; cls_i changed to STORE during MEM must not set dmem_we
      imem_ack = 1'b1; cls = 3'd1; settle(); tick();
      imem_ack = 1'b0; settle();
      chk("ld c1 state", state, 1);
      tick();
      cls = 3'd2; settle();
      chk("ld c2 state", state, 2);
      tick();
      settle();
      chk("ld c3 state", state, 3);
      chk("ld c3 outs", outs(), 7'b0000010);
      tick(); settle();
      chk("ld c4 state", state, 3);
      tick(); settle();
      chk("ld c5 state", state, 3);
      tick();
      dmem_ack = 1'b1; settle();
      chk("ld c6 state", state, 3);
      chk("ld c6 outs", outs(), 7'b0000010);
      chk("ld c6 stall", stall_cnt, 3);
      tick();
      dmem_ack = 1'b0; settle();
      chk("ld c7 state", state, 4);
      chk("ld c7 outs", outs(), 7'b0111000);
      tick(); settle();
      chk("ld end state", state, 0);
      chk("ld instret", instret, 2);
      chk("ld stall", stall_cnt, 3);
      $display("instr LOAD instret=%0d stall=%0d", instret, stall_cnt);

      // STORE with immediate ack
      imem_ack = 1'b1; cls = 3'd2; settle(); tick();
      imem_ack = 1'b0; settle(); tick();
      settle(); tick();
      dmem_ack = 1'b1; settle();
      chk("st mem state", state, 3);
      chk("st mem outs", outs(), 7'b0011011);
      tick();
      dmem_ack = 1'b0; settle();
      chk("st end state", state, 0);
      chk("st instret", instret, 3);
      $display("instr STORE instret=%0d stall=%0d", instret, stall_cnt);

      // JUMP retires from ID
      imem_ack = 1'b1; cls = 3'd4; settle(); tick();
      imem_ack = 1'b0; settle();
      chk("jmp id state", state, 1);
      chk("jmp id outs", outs(), 7'b0011000);
      tick(); settle();
      chk("jmp end state", state, 0);
      chk("jmp instret", instret, 4);
      $display("instr JUMP instret=%0d stall=%0d", instret, stall_cnt);

      // BRANCH retires from EXE
      imem_ack = 1'b1; cls = 3'd3; settle(); tick();
      imem_ack = 1'b0; settle(); tick();
      settle();
      chk("br exe state", state, 2);
      chk("br exe outs", outs(), 7'b0011000);
      tick(); settle();
      chk("br end state", state, 0);
      chk("br instret", instret, 5);
      chk("br stall", stall_cnt, 3);
      $display("instr BRANCH instret=%0d stall=%0d", instret, stall_cnt);

      // imem_ack arrives on the exact timeout cycle: no ERR
      for (int i = 0; i < 15; i++) tick();
      settle();
      chk("tmo edge state", state, 0);
      chk("tmo edge stall", stall_cnt, 18);
      imem_ack = 1'b1; cls = 3'd0; settle();
      chk("tmo edge outs", outs(), 7'b1000100);
      tick();
      imem_ack = 1'b0; settle();
      chk("tmo edge id", state, 1);
      chk("tmo edge stall2", stall_cnt, 18);
      tick(); tick(); tick(); settle();
      chk("tmo edge end", state, 0);
      chk("tmo edge instret", instret, 6);
      $display("instr ALU-late instret=%0d stall=%0d", instret, stall_cnt);

      // Stray dmem_ack in IF does not advance
      dmem_ack = 1'b1; settle(); tick();
      dmem_ack = 1'b0; settle();
      chk("stray state", state, 0);
      chk("stray stall", stall_cnt, 19);

      // HALT, then go after 5 cycles; acks in HALT are ignored
      imem_ack = 1'b1; cls = 3'd5; settle(); tick();
      imem_ack = 1'b0; settle(); tick();
      for (int i = 0; i < 5; i++) begin
         imem_ack = 1'b1; dmem_ack = 1'b1; go = (i == 4);
         settle();
         chk("halt halted", halted, 1);
         chk("halt outs", outs(), 7'b0000000);
         tick();
      end
      go = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; settle();
      chk("halt exit state", state, 0);
      chk("halt exit halted", halted, 0);
      chk("halt instret", instret, 6);
      $display("instr HALT instret=%0d stall=%0d", instret, stall_cnt);

      // Illegal class -> sticky ERR
      imem_ack = 1'b1; cls = 3'd7; settle(); tick();
      imem_ack = 1'b0; settle();
      chk("ill id state", state, 1);
      tick(); settle();
      chk("ill err state", state, 6);
      chk("ill err flag", err, 1);
      go = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
      tick(); tick(); tick(); settle();
      chk("ill sticky state", state, 6);
      chk("ill sticky outs", outs(), 7'b0000000);
      go = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
      rst_n = 1'b0; settle();
      chk("ill rst state", state, 0);
      chk("ill rst err", err, 0);
      chk("ill rst instret", instret, 0);
      chk("ill rst stall", stall_cnt, 0);
      tick();
      rst_n = 1'b1; settle();
      $display("instr ILLEGAL err cleared by reset");

      // imem_ack never arrives: ERR after 16 IF cycles
      for (int i = 0; i < 16; i++) begin
         settle();
         chk("tmo if state", state, 0);
         tick();
      end
      settle();
      chk("tmo err state", state, 6);
      chk("tmo err flag", err, 1);
      chk("tmo stall", stall_cnt, 16);
      imem_ack = 1'b1; tick(); tick(); settle();
      chk("tmo err sticky", err, 1);
      imem_ack = 1'b0;
      rst_n = 1'b0; settle();
      chk("tmo rst err", err, 0);
      tick();
      rst_n = 1'b1; settle();
      $display("instr TIMEOUT err entered and cleared");

      // STORE to get instret=1, then reset in the middle of a LOAD's MEM wait
      imem_ack = 1'b1; cls = 3'd2; settle(); tick();
      imem_ack = 1'b0; settle(); tick();
      settle(); tick();
      dmem_ack = 1'b1; settle(); tick();
      dmem_ack = 1'b0; settle();
      chk("pre rst instret", instret, 1);
      imem_ack = 1'b1; cls = 3'd1; settle(); tick();
      imem_ack = 1'b0; settle(); tick();
      settle(); tick();
      settle();
      chk("mid mem state", state, 3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid rst state", state, 0);
      chk("mid rst instret", instret, 0);
      chk("mid rst stall", stall_cnt, 0);
      chk("mid rst outs", outs(), 7'b0000000);
      dmem_ack = 1'b1; tick();
      chk("mid rst held", state, 0);
      chk("mid rst held instret", instret, 0);
      dmem_ack = 1'b0;
      rst_n = 1'b1; tick(); settle();
      chk("post rst state", state, 0);
      chk("post rst stall", stall_cnt, 1);
      $display("instr LOAD aborted by reset instret=%0d", instret);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
